// File: rtl/uart_tx_mapped.sv
// rtl/uart_tx_mapped.sv - memory-mapped 8N1 UART transmitter with TX FIFO and level interrupt
module uart_tx_mapped #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [2:0] addr,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    output logic       tx_out,
    output logic       irq,
    output logic [2:0] irq_id
);

    localparam int          PTR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic             wr_prev, rd_prev;
    logic [1:0]       ctrl;
    logic [15:0]      divisor;
    logic             overflow;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    state_t           state;
    logic [7:0]       shift;
    logic [2:0]       bit_idx;
    logic [15:0]      bit_div;
    logic [15:0]      timer;

    logic wr_evt, rd_evt, rd_active;
    logic empty, full, busy, bit_done;
    logic push_req, push_ok, pop;
    logic [7:0] rdata;

    assign wr_evt    = ~cs & ~wr & wr_prev;
    assign rd_evt    = ~cs & ~rd & rd_prev;
    assign rd_active = ~cs & ~rd;
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign busy      = (state != S_IDLE);
    assign bit_done  = (timer == bit_div);

    // A pop happens at the IDLE decision or at the end of a stop bit, so frames can run back-to-back.
    assign pop      = ctrl[0] & ~empty & ((state == S_IDLE) | ((state == S_STOP) & bit_done));
    assign push_req = wr_evt & (addr == 3'd0);
    assign push_ok  = push_req & (~full | pop);

    always_comb begin
        rdata = 8'h00;
        case (addr)
            3'd1:    rdata = {4'b0000, overflow, busy, full, empty};
            3'd2:    rdata = {6'b000000, ctrl};
            3'd3:    rdata = divisor[7:0];
            3'd4:    rdata = divisor[15:8];
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_prev  <= 1'b1;
            rd_prev  <= 1'b1;
            ctrl     <= 2'b00;
            divisor  <= DIV_RST;
            out_data <= 8'h00;
        end else begin
            wr_prev <= wr;
            rd_prev <= rd;
            if (rd_active)
                out_data <= rdata;
            if (wr_evt) begin
                case (addr)
                    3'd2:    ctrl <= in_data[1:0];
                    3'd3:    divisor[7:0] <= in_data;
                    3'd4:    divisor[15:8] <= in_data;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_req & full & ~pop)
                overflow <= 1'b1;
            else if (rd_evt & (addr == 3'd1))
                overflow <= 1'b0;
        end
    end

    // tx_out is driven from the state transitions so the line changes on the same edge as the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            shift   <= 8'h00;
            bit_idx <= 3'd0;
            bit_div <= 16'd0;
            timer   <= 16'd0;
            tx_out  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_out <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        bit_div <= divisor;
                        timer   <= 16'd0;
                        tx_out  <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        timer   <= 16'd0;
                        bit_idx <= 3'd0;
                        tx_out  <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        timer <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            tx_out <= 1'b1;
                            state  <= S_STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            tx_out  <= shift[1];
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        timer <= 16'd0;
                        if (pop) begin
                            shift   <= mem[rd_ptr];
                            bit_div <= divisor;
                            tx_out  <= 1'b0;
                            state   <= S_START;
                        end else begin
                            tx_out <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    tx_out <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq    <= 1'b0;
            irq_id <= 3'd0;
        end else begin
            irq <= ctrl[1] & (overflow | (empty & ~busy));
            if (ctrl[1] & overflow)
                irq_id <= 3'd2;
            else if (ctrl[1] & empty & ~busy)
                irq_id <= 3'd1;
            else
                irq_id <= 3'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mapped.sv
// tb/tb_uart_tx_mapped.sv - scoreboard bench: serial frames decoded and matched against a queue model
module tb_uart_tx_mapped;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b1, rd = 1'b1, wr = 1'b1;
    logic [2:0] addr = 3'd0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] out_data;
    logic       tx_out, irq;
    logic [2:0] irq_id;

    uart_tx_mapped #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
        .in_data(in_data), .out_data(out_data), .tx_out(tx_out), .irq(irq), .irq_id(irq_id)
    );

    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;
    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: pending bytes, sticky overflow, register shadows.
    logic [7:0] exp_q[$];
    longint     start_q[$];
    int         mf_cnt = 0;
    bit         model_ovf = 0;
    int         model_div = 15;
    logic [1:0] model_ctrl = 2'b00;
    bit         mon_en = 1;

    function automatic void check(string name, int act, int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        cs = 1'b0; wr = 1'b0; addr = a; in_data = d;
        @(posedge clock); #1;
        cs = 1'b1; wr = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] v);
        @(posedge clock); #1;
        cs = 1'b0; rd = 1'b0; addr = a;
        @(posedge clock); #1;
        v = out_data;
        cs = 1'b1; rd = 1'b1;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        bus_write(3'd0, b);
        if (mf_cnt < 4) begin
            mf_cnt++;
            exp_q.push_back(b);
        end else begin
            model_ovf = 1;
        end
    endtask

    task automatic set_ctrl(input logic [1:0] c);
        bus_write(3'd2, {6'b0, c});
        model_ctrl = c;
    endtask

    task automatic set_div(input int d);
        bus_write(3'd3, 8'(d));
        bus_write(3'd4, 8'(d >> 8));
        model_div = d;
    endtask

    task automatic check_status_idle(input string name);
        logic [7:0] v;
        bus_read(3'd1, v);
        check(name, v, {4'b0, model_ovf, 1'b0, mf_cnt == 4, mf_cnt == 0});
        model_ovf = 0;
    endtask

    task automatic check_irq(input string name);
        bit ie, cond_e;
        repeat (3) @(posedge clock);
        #1;
        ie = model_ctrl[1];
        cond_e = (mf_cnt == 0);
        check({name, "_irq"}, irq, ie & (model_ovf | cond_e));
        check({name, "_irq_id"}, irq_id, !ie ? 0 : model_ovf ? 2 : cond_e ? 1 : 0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_drain_timeout"}, exp_q.size(), 0);
        repeat (model_div + 4) @(negedge clock);
        mf_cnt = 0;
        check_status_idle({name, "_status_after"});
    endtask

    // Monitor: decode every frame seen on tx_out at mid-bit and match it to the scoreboard head.
    initial begin : monitor
        int p;
        logic [9:0] frame;
        forever begin
            @(negedge clock);
            if (mon_en && !reset && tx_out == 1'b0) begin
                p = model_div + 1;
                start_q.push_back(cyc);
                repeat (p / 2) @(negedge clock);
                frame[0] = tx_out;
                for (int i = 1; i <= 9; i++) begin
                    repeat (p) @(negedge clock);
                    frame[i] = tx_out;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {22'b0, frame}, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("frame", {22'b0, frame}, {22'b0, 1'b1, e, 1'b0});
                end
                repeat (p - p / 2 - 1) @(negedge clock);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] v;
        bit seen_low;
        int n;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        check("reset_tx_out", tx_out, 1);
        check("reset_irq", irq, 0);
        check_status_idle("reset_status");
        bus_read(3'd3, v); check("reset_div_lo", v, 8'h0F);
        bus_read(3'd4, v); check("reset_div_hi", v, 8'h00);
        bus_read(3'd2, v); check("reset_ctrl", v, 8'h00);
        bus_read(3'd6, v); check("unmapped_read", v, 8'h00);

        // Single frame 0xA5 at 4 clocks per bit.
        set_div(3);
        set_ctrl(2'b01);
        tx_byte(8'hA5);
        repeat (8) @(posedge clock);
        bus_read(3'd1, v); check("midframe_status", v, 8'h05);
        drain("a5");

        // Overflow with transmitter disabled, then back-to-back drain.
        set_ctrl(2'b00);
        for (int i = 1; i <= 5; i++) tx_byte(8'(i * 8'h11));
        check_status_idle("ovf_status1");
        check_status_idle("ovf_status2");
        start_q.delete();
        set_ctrl(2'b01);
        drain("b2b");
        check("b2b_frames", start_q.size(), 4);
        for (int k = 0; k + 1 < start_q.size(); k++)
            check("b2b_gap", int'(start_q[k+1] - start_q[k]), 10 * (model_div + 1));
        set_ctrl(2'b00);

        // A held write strobe pushes exactly once.
        @(posedge clock); #1;
        cs = 1'b0; wr = 1'b0; addr = 3'd0; in_data = 8'h5A;
        repeat (10) @(posedge clock);
        #1; cs = 1'b1; wr = 1'b1;
        mf_cnt = 1; exp_q.push_back(8'h5A);
        check_status_idle("held_wr_status");
        set_ctrl(2'b01);
        drain("held_wr");

        // Interrupt causes and priority.
        set_ctrl(2'b11);
        check_irq("irq_empty");
        set_ctrl(2'b10);
        for (int i = 0; i < 5; i++) tx_byte(8'($urandom));
        check_irq("irq_ovf");
        check_status_idle("irq_status");
        check_irq("irq_after_clear");
        set_ctrl(2'b11);
        drain("irq_drain");
        check_irq("irq_empty_again");
        set_ctrl(2'b01);
        check_irq("irq_disabled");
        set_ctrl(2'b00);

        // Randomized rounds: random divisor, random fill level including overflow.
        for (int r = 0; r < 5; r++) begin
            set_div(int'($urandom_range(0, 5)));
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) tx_byte(8'($urandom));
            check_status_idle("rand_status");
            set_ctrl(2'b01);
            drain("rand");
            set_ctrl(2'b00);
        end

        // Divisor written mid-frame applies only to the next frame.
        set_div(2);
        tx_byte(8'h3C);
        set_ctrl(2'b01);
        repeat (4) @(posedge clock);
        bus_write(3'd3, 8'd5);
        drain("div_mid");
        model_div = 5;
        set_ctrl(2'b00);
        tx_byte(8'hC3);
        set_ctrl(2'b01);
        drain("div_next");
        set_ctrl(2'b00);

        // Reset in the middle of data bit 3 of 0xFF with two more entries queued.
        set_div(3);
        mon_en = 0;
        bus_write(3'd0, 8'hFF);
        bus_write(3'd0, 8'h00);
        bus_write(3'd0, 8'h00);
        bus_write(3'd2, 8'h01);
        n = 0;
        while (tx_out !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("rst_frame_start_timeout", n < 200, 1);
        repeat (4 * 4 + 2) @(negedge clock);
        #1 reset = 1'b1;
        #1 check("rst_tx_out", tx_out, 1);
        check("rst_irq", irq, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        mf_cnt = 0; model_ovf = 0; model_div = 15; model_ctrl = 2'b00;
        exp_q.delete();
        check_status_idle("rst_status");
        set_ctrl(2'b01);
        seen_low = 0;
        repeat (300) begin
            @(negedge clock);
            if (tx_out !== 1'b1) seen_low = 1;
        end
        check("rst_no_frames", seen_low, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
